simon32_64_keysched: RTL
========================

SIMON32_64_KEYSCHED -- requirements
Module: simon32_64_keysched

Interface
REQ-001 Parameter: NumRounds, 32, number of 16-bit round keys emitted per loaded key (fixed by Simon32/64; other values unsupported).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-004 key  input  64  master key; key[15:0]=k0, key[31:16]=k1, key[47:32]=k2, key[63:48]=k3.
REQ-005 key_valid  input  1  upstream asserts when key is valid.
REQ-006 key_ready  output  1  high when block can accept a new key (IDLE state).
REQ-007 rk  output  16  current round key k[rk_index].
REQ-008 rk_valid  output  1  rk/rk_index/rk_last valid.
REQ-009 rk_ready  input  1  downstream round datapath accepts current round key.
REQ-010 rk_index  output  5  round number 0..31 of rk.
REQ-011 rk_last  output  1  high when rk_valid and rk_index==31.

Function
REQ-012 Two states, IDLE and RUN; key_ready = (state==IDLE).
REQ-013 IDLE->RUN on key_valid&key_ready at posedge; key latched into 4x16-bit window {w3,w2,w1,w0}={k3,k2,k1,k0}; index counter cleared to 0.
REQ-014 In RUN: rk_valid=1, rk=w0, rk_index=counter; first key (k0) presented the cycle after key acceptance (1-cycle latency).
REQ-015 Round key advance only on rk_valid&rk_ready; when rk_ready=0, rk, rk_index, rk_last and window SHALL hold unchanged.
REQ-016 On advance: window shifts {w3,w2,w1,w0} <= {knew,w3,w2,w1}; counter increments.
REQ-017 knew = 0xFFFC ^ z0[i] ^ w0 ^ t ^ ror(t,1), t = ror(w3,3) ^ w1, i = counter (generated key index i+4), ror = 16-bit rotate right, z0[i] in bit 0.
REQ-018 z0 sequence (element 0 first): 11111010001001010110000111001101111101000100101011000011100110; only elements 0..27 are used; hardwired constant.
REQ-019 Keys k0..k3 emitted unmodified; k4..k31 from REQ-017; generating beyond k31 SHALL not affect outputs.
REQ-020 Advance with rk_index==31 (rk_last handshake) -> IDLE next cycle; rk_valid=0, key_ready=1.
REQ-021 key_valid during RUN ignored (key_ready=0); key_valid in same cycle as rk_last handshake not accepted; earliest acceptance is following cycle.
REQ-022 Throughput with rk_ready held 1: 32 keys in 32 consecutive cycles; back-to-back keys separated by one IDLE cycle (33 cycles/key).
REQ-023 rk, rk_index SHALL be 0 whenever rk_valid=0.

Reset
REQ-024 reset asserted (any time, incl. mid-RUN) -> immediately state=IDLE, window=0, counter=0, rk=0, rk_index=0, rk_valid=0, rk_last=0, key_ready=1.
REQ-025 Aborted schedule not resumed after reset release; new key required.
REQ-026 First key acceptance possible on first posedge after reset deasserts.

Verification
REQ-027 Vector: key=0x1918111009080100, key_valid 1 cycle, rk_ready=1 -> rk sequence 0x0100,0x0908,0x1110,0x1918,0x71C3,... rk_index 0..31 consecutive, rk_last only at 31; full 32-key sequence matches golden Simon32/64 model.
REQ-028 End-to-end: schedule from REQ-027 fed to round datapath with plaintext 0x65656877 -> ciphertext 0xC69BE9BB.
REQ-029 Stall: deassert rk_ready for 5 cycles at rk_index=4 -> rk=0x71C3, rk_index=4 held all 5 cycles; sequence resumes unchanged.
REQ-030 Back-to-back: key_valid held 1 with two different keys -> second accepted exactly one cycle after rk_last handshake; key_valid during RUN never accepted.
REQ-031 Reset at rk_index=10 -> same cycle rk_valid=0, rk=0, key_ready=1; new key after release restarts at rk_index=0 with its k0.
REQ-032 Random key/rk_ready stress (1000 keys) vs reference model; zero mismatches, no dropped or duplicated indices.

Source files
------------

// File: rtl/simon32_64_keysched_if.sv
// Handshake bundle for the Simon32/64 key scheduler: master key in, round keys out.
// The slave modport is the scheduler's view of the bundle; the master modport is the view of whatever drives and consumes it.
interface simon32_64_keysched_if;
    logic [63:0] key;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] rk;
    logic        rk_valid;
    logic        rk_ready;
    logic [4:0]  rk_index;
    logic        rk_last;

    modport slave (
        input  key, key_valid, rk_ready,
        output key_ready, rk, rk_valid, rk_index, rk_last
    );

    modport master (
        output key, key_valid, rk_ready,
        input  key_ready, rk, rk_valid, rk_index, rk_last
    );
endinterface

// File: rtl/simon32_64_keysched.sv
// Simon32/64 key schedule: streams the 32 round keys of a loaded 64-bit master key,
// one per rk handshake, using a 4-word sliding window and the z0 constant sequence.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a master key; key_ready high, no round key shown
// RUN   | presenting k[cnt] = w0; advances on each rk_ready
module simon32_64_keysched #(
    parameter int NumRounds = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    simon32_64_keysched_if.slave        bus
);
    // z0 elements 0..31, element 0 leftmost; only 0..27 ever reach an emitted key
    localparam logic [0:31] Z0      = 32'b11111010001001010110000111001101;
    localparam logic [4:0]  LastIdx = 5'(NumRounds - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [3:0][15:0]   w_q, w_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [15:0]        t;
    logic [15:0]        knew;
    logic               run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        t       = {w_q[3][2:0], w_q[3][15:3]} ^ w_q[1];
        knew    = 16'hFFFC ^ {15'd0, Z0[cnt_q]} ^ w_q[0] ^ t ^ {t[0], t[15:1]};
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    state_d = RUN;
                    w_d     = bus.key;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // keys past k31 are still generated on the last advance but never shown
                if (bus.rk_ready) begin
                    w_d   = {knew, w_q[3:1]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LastIdx) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign run           = (state_q == RUN);
    assign bus.key_ready = (state_q == IDLE);
    assign bus.rk_valid  = run;
    assign bus.rk        = run ? w_q[0] : '0;
    assign bus.rk_index  = run ? cnt_q : '0;
    assign bus.rk_last   = run && (cnt_q == LastIdx);
endmodule
